jtdsp16_sout_rx: RTL and testbench
==================================

# jtdsp16_sout_rx

Serial-output receiver sitting directly downstream of the DSP16 serial port. It consumes the port's serial clock, data and load strobes, rebuilds 16-bit MSB-first words, pairs them into left/right stereo samples and presents them as a parallel sample with a one-cycle valid strobe. The Q-Sound top level uses it to feed the audio mixer without an external DAC model.

## Interface
Parameters:
- WORD_W, 16, bits per serial word (MSB first); only 16 is supported by the serial port configuration used.
- ERR_W, 8, width of the saturating framing-error counter.

Ports:
- clk  input  1  system clock; the serial port runs on the same clock.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- ock  input  1  serial output clock from the DSP16 port; a bit is taken on each rising edge seen in clk.
- sio_do  input  1  serial data, valid when an ock rising edge is seen.
- old  input  1  output load strobe; high at an ock rising edge marks the first bit of a word.
- sadd  input  1  channel tag, sampled with the first bit: 1 = left, 0 = right.
- left  output  16  last complete left sample, signed.
- right  output  16  last complete right sample, signed.
- sample  output  1  one-cycle pulse: left/right hold a new stereo pair.
- err_cnt  output  ERR_W  saturating count of framing errors.
- err_clr  input  1  synchronous clear of err_cnt.

## Operation
- Edge detect: ock_l registers ock; bit event be = ock & ~ock_l. All state advances only on be, except pulse clear and err_clr.
- FSM states: IDLE, SHIFT, WAITR.
  - IDLE: be & old -> load shreg with sio_do, bitcnt=1, latch chan=sadd, go SHIFT. be & ~old ignored.
  - SHIFT: be & ~old -> shreg={shreg[14:0],sio_do}, bitcnt+1. When the shift raises bitcnt to 16, the word is complete: chan=1 stores it in lhold and goes WAITR; chan=0 (right without pending left) is an order error, err_cnt+1, go IDLE.
  - SHIFT: be & old with bitcnt<16 -> truncated word, err_cnt+1, word discarded, restart as a new word (same action as IDLE with old).
  - WAITR: be & old -> start next word as in IDLE but remain logically paired; if that word completes with chan=0: left<=lhold, right<=word, sample pulse. If it completes with chan=1: err_cnt+1, lhold replaced, stay paired (WAITR).
- Error in WAITR (truncated word): err_cnt+1, lhold kept, pairing kept.
- err_cnt saturates at all-ones; err_clr wins over a same-cycle increment (result 0).
- Reset values: left=0, right=0, sample=0, err_cnt=0, state IDLE, bitcnt=0, ock_l=0 (so ock high at reset release gives a bit event on the first cycle).

## Timing
- Word completion: the 16th be is at cycle N; shreg holds the full word after the clk edge ending N; left/right update and sample=1 during cycle N+1; sample=0 in N+2.
- sample never lasts more than one cycle; minimum spacing between pulses is 32 bit events.
- ock high for several clk cycles produces exactly one bit event.
- Reset mid-word: partial word is dropped, no pulse, no error counted.

## Structure
- Shared package jtdsp16_pkg: FSM state encoding (IDLE/SHIFT/WAITR), WORD_W default, channel constants LEFT=1/RIGHT=0.
- One sub-module natural: jtdsp16_sout_shreg (edge detect, 16-bit shift register, bit counter, word_done pulse); pairing FSM and error counter stay in the top.

## Test plan
- Left 0x8001 (sadd=1) then right 0x7FFE (sadd=0), ock period 12 clk -> one sample pulse, left=0x8001, right=0x7FFE, err_cnt=0.
- Two stereo pairs back to back (0x1234/0xABCD, 0x0F0F/0xF0F0) -> two pulses 32 bit events apart, values updated each time.
- old reasserted after 9 bits of a left word, then full pair 0x5555/0xAAAA -> err_cnt=1, single pulse with 0x5555/0xAAAA.
- Right word with no preceding left -> no pulse, err_cnt=1; then normal pair -> pulse, err_cnt stays 1.
- Force 300 truncated words with ERR_W=8 -> err_cnt=0xFF; err_clr coincident with another error -> err_cnt=0.
- rst asserted after 8 bits of a right word in WAITR -> all outputs 0 next cycle, following pair decoded correctly.

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 serial-output receiver: FSM states,
// default word width and channel tag values.
package jtdsp16_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAITR = 2'd2
   } sout_state_t;

   localparam int   DEF_WORD_W = 16;
   localparam logic LEFT       = 1'b1;
   localparam logic RIGHT      = 1'b0;

endpackage

// File: rtl/jtdsp16_sout_shreg.sv
// Serial word assembler: ock rising-edge detect, MSB-first shift register and
// bit counter. Word completion and truncation are reported combinationally.
module jtdsp16_sout_shreg #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ock,
   input  logic              sio_do,
   input  logic              old,
   output logic              start,
   output logic              trunc,
   output logic              word_done,
   output logic [WORD_W-1:0] word_next
);

   localparam int CNT_W = $clog2(WORD_W + 1);

   logic              ock_l_reg;
   logic              active_reg;
   logic [WORD_W-1:0] shreg_reg;
   logic [CNT_W-1:0]  bitcnt_reg;
   logic              be;
   logic              shift;

   assign be        = ock & ~ock_l_reg;
   assign start     = be & old;
   assign trunc     = start & active_reg;
   assign shift     = be & ~old & active_reg;
   assign word_next = {shreg_reg[WORD_W-2:0], sio_do};
   // The completing bit is exposed before it is registered so the pairing
   // logic can publish the sample one cycle after the last bit event.
   assign word_done = shift && (bitcnt_reg == CNT_W'(WORD_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         ock_l_reg  <= 1'b0;
         active_reg <= 1'b0;
         shreg_reg  <= '0;
         bitcnt_reg <= '0;
      end else begin
         ock_l_reg <= ock;
         if (start) begin
            shreg_reg  <= WORD_W'(sio_do);
            bitcnt_reg <= CNT_W'(1);
            active_reg <= 1'b1;
         end else if (shift) begin
            shreg_reg  <= word_next;
            bitcnt_reg <= bitcnt_reg + CNT_W'(1);
            if (word_done)
               active_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/jtdsp16_sout_rx.sv
// DSP16 serial-output receiver: pairs left/right serial words into stereo
// samples and counts framing errors with a saturating counter.
module jtdsp16_sout_rx
   import jtdsp16_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ock,
   input  logic              sio_do,
   input  logic              old,
   input  logic              sadd,
   output logic [WORD_W-1:0] left,
   output logic [WORD_W-1:0] right,
   output logic              sample,
   output logic [ERR_W-1:0]  err_cnt,
   input  logic              err_clr
);

   sout_state_t       state_reg;
   logic              chan_reg;
   logic [WORD_W-1:0] lhold_reg;
   logic              start;
   logic              trunc;
   logic              word_done;
   logic [WORD_W-1:0] word_next;
   logic              err_evt;

   jtdsp16_sout_shreg #(.WORD_W(WORD_W)) u_shreg (
      .clk       (clk),
      .rst       (rst),
      .ock       (ock),
      .sio_do    (sio_do),
      .old       (old),
      .start     (start),
      .trunc     (trunc),
      .word_done (word_done),
      .word_next (word_next)
   );

   // Framing errors: truncated word, right word with no pending left, or a
   // second left word while already holding one.
   assign err_evt = trunc
                  | (word_done && state_reg == SHIFT && chan_reg == RIGHT)
                  | (word_done && state_reg == WAITR && chan_reg == LEFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         chan_reg  <= RIGHT;
         lhold_reg <= '0;
         left      <= '0;
         right     <= '0;
         sample    <= 1'b0;
      end else begin
         sample <= 1'b0;
         if (start)
            chan_reg <= sadd;
         case (state_reg)
            IDLE: begin
               if (start)
                  state_reg <= SHIFT;
            end
            SHIFT: begin
               if (word_done) begin
                  if (chan_reg == LEFT) begin
                     lhold_reg <= word_next;
                     state_reg <= WAITR;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            WAITR: begin
               if (word_done) begin
                  if (chan_reg == RIGHT) begin
                     left      <= lhold_reg;
                     right     <= word_next;
                     sample    <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     lhold_reg <= word_next;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || err_clr)
         err_cnt <= '0;
      else if (err_evt && err_cnt != '1)
         err_cnt <= err_cnt + ERR_W'(1);
   end

endmodule

// File: tb/tb_jtdsp16_sout_rx.sv
// Scoreboard bench for jtdsp16_sout_rx: stimulus pushes expected stereo pairs,
// a monitor pops and compares on every sample pulse.
module tb_jtdsp16_sout_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ock = 1'b0;
   logic        sio_do = 1'b0;
   logic        old = 1'b0;
   logic        sadd = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] left;
   logic [15:0] right;
   logic        sample;
   logic [7:0]  err_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_pulse = 0;
   int prev_pulse = 0;
   logic sample_d = 1'b0;
   logic [31:0] exp_q[$];

   jtdsp16_sout_rx #(.WORD_W(16), .ERR_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .ock     (ock),
      .sio_do  (sio_do),
      .old     (old),
      .sadd    (sadd),
      .left    (left),
      .right   (right),
      .sample  (sample),
      .err_cnt (err_cnt),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && sample) begin
         logic [31:0] e;
         checks++;
         if (sample_d) begin
            failures++;
            $display("FAIL pulse_width: actual=2+ cycles required=1 cycle");
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_sample: actual=%h/%h required=no pulse", left, right);
         end else begin
            e = exp_q.pop_front();
            if ({left, right} !== e) begin
               failures++;
               $display("FAIL sample_pair: actual=%h/%h required=%h/%h",
                        left, right, e[31:16], e[15:0]);
            end else
               $display("sample left=%h right=%h ok", left, right);
         end
         prev_pulse = last_pulse;
         last_pulse = cyc;
      end
      sample_d = sample;
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end else
         $display("check %s = %0h ok", name, act);
   endtask

   // One ock period of 12 clk per bit: 6 low, 6 high.
   task automatic send_word(input logic [15:0] w, input logic ch, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ock    = 1'b0;
         sio_do = w[15-i];
         old    = (i == 0);
         sadd   = ch;
         repeat (6) @(negedge clk);
         ock = 1'b1;
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
      exp_q.push_back({l, r});
      send_word(l, 1'b1, 16);
      send_word(r, 1'b0, 16);
   endtask

   task automatic clear_err();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_left", 32'(left), 32'h0);
      check_eq("reset_right", 32'(right), 32'h0);
      check_eq("reset_sample", 32'(sample), 32'h0);
      check_eq("reset_err", 32'(err_cnt), 32'h0);

      // Basic pair
      send_pair(16'h8001, 16'h7FFE);
      repeat (4) @(negedge clk);
      check_eq("pair1_err", 32'(err_cnt), 32'h0);
      check_eq("pair1_drained", 32'(exp_q.size()), 32'h0);

      // Back-to-back pairs, 32 bit events apart
      send_pair(16'h1234, 16'hABCD);
      send_pair(16'h0F0F, 16'hF0F0);
      repeat (4) @(negedge clk);
      check_eq("pair_spacing", 32'(last_pulse - prev_pulse), 32'd384);
      check_eq("pair2_err", 32'(err_cnt), 32'h0);

      // Truncated left word then a clean pair
      send_word(16'hFFFF, 1'b1, 9);
      send_pair(16'h5555, 16'hAAAA);
      repeat (4) @(negedge clk);
      check_eq("trunc_err", 32'(err_cnt), 32'h1);

      // Orphan right word
      clear_err();
      send_word(16'h1111, 1'b0, 16);
      repeat (4) @(negedge clk);
      check_eq("orphan_err", 32'(err_cnt), 32'h1);
      send_pair(16'h2222, 16'h3333);
      repeat (4) @(negedge clk);
      check_eq("orphan_err_after_pair", 32'(err_cnt), 32'h1);

      // Saturation: 301 starts give 300 truncations
      clear_err();
      for (int k = 0; k < 301; k++)
         send_word(16'hC000, 1'b1, 2);
      repeat (2) @(negedge clk);
      check_eq("err_saturated", 32'(err_cnt), 32'hFF);
      @(negedge clk);
      ock = 1'b0; old = 1'b1; sadd = 1'b1; sio_do = 1'b0;
      repeat (6) @(negedge clk);
      ock = 1'b1; err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_eq("err_clr_wins", 32'(err_cnt), 32'h0);
      repeat (4) @(negedge clk);

      // Reset mid right word while paired
      send_word(16'h4444, 1'b1, 16);
      check_eq("pre_reset_err", 32'(err_cnt), 32'h1);
      send_word(16'h9999, 1'b0, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midreset_left", 32'(left), 32'h0);
      check_eq("midreset_right", 32'(right), 32'h0);
      check_eq("midreset_sample", 32'(sample), 32'h0);
      check_eq("midreset_err", 32'(err_cnt), 32'h0);
      send_pair(16'h6789, 16'h9876);
      repeat (4) @(negedge clk);
      check_eq("post_reset_err", 32'(err_cnt), 32'h0);

      check_eq("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
